// File: rtl/id_pipe_if.sv
// Handshake bundle for the ID stage: the upstream instruction channel and the
// registered ID/EX channel. Signal names match the original flat port list.
interface id_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [31:0]       pc_i;
  logic [31:0]       inst_i;

  logic              out_valid_o;
  logic              out_ready_i;
  logic [7:0]        aluop_o;
  logic [2:0]        alusel_o;
  logic [DATA_W-1:0] reg1_o;
  logic [DATA_W-1:0] reg2_o;
  logic [REG_AW-1:0] wd_o;
  logic              wreg_o;
  logic [31:0]       pc_o;
  logic              invalid_inst_o;

  // Environment side: feeds instructions and consumes the ID/EX register.
  modport master (
    output in_valid_i, pc_i, inst_i, out_ready_i,
    input  in_ready_o, out_valid_o, aluop_o, alusel_o, reg1_o, reg2_o,
    input  wd_o, wreg_o, pc_o, invalid_inst_o
  );

  // Stage side.
  modport slave (
    input  in_valid_i, pc_i, inst_i, out_ready_i,
    output in_ready_o, out_valid_o, aluop_o, alusel_o, reg1_o, reg2_o,
    output wd_o, wreg_o, pc_o, invalid_inst_o
  );
endinterface

// File: rtl/id_pipe.sv
// Registered OpenMIPS decode stage: logic/shift decode, EX/MEM forwarding,
// load-use bubble insertion and a valid/ready-held ID/EX register.
module id_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  id_pipe_if.slave          bus,

  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [REG_AW-1:0] reg1_addr_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,

  input  logic              ex_wreg_i,
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,

  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [7:0] ALU_AND = 8'h24;
  localparam logic [7:0] ALU_OR  = 8'h25;
  localparam logic [7:0] ALU_XOR = 8'h26;
  localparam logic [7:0] ALU_NOR = 8'h27;
  localparam logic [7:0] ALU_SLL = 8'h7C;
  localparam logic [7:0] ALU_SRL = 8'h02;
  localparam logic [7:0] ALU_SRA = 8'h03;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } state_t;

  state_t state_q, state_d;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  assign op    = bus.inst_i[31:26];
  assign rs    = bus.inst_i[25:21];
  assign rt    = bus.inst_i[20:16];
  assign rd    = bus.inst_i[15:11];
  assign shamt = bus.inst_i[10:6];
  assign funct = bus.inst_i[5:0];
  assign imm   = bus.inst_i[15:0];

  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic              dec_re1, dec_re2;
  logic [REG_AW-1:0] dec_wd;
  logic              dec_wreg;
  logic [DATA_W-1:0] dec_imm1, dec_imm2;
  logic              dec_invalid;

  always_comb begin
    dec_aluop   = '0;
    dec_alusel  = SEL_NOP;
    dec_re1     = 1'b0;
    dec_re2     = 1'b0;
    dec_wd      = '0;
    dec_imm1    = '0;
    dec_imm2    = '0;
    dec_invalid = 1'b1;
    case (op)
      OP_ORI, OP_ANDI, OP_XORI: begin
        dec_alusel  = SEL_LOGIC;
        dec_re1     = 1'b1;
        dec_imm2    = DATA_W'(imm);
        dec_wd      = REG_AW'(rt);
        dec_invalid = 1'b0;
        case (op)
          OP_ANDI: dec_aluop = ALU_AND;
          OP_XORI: dec_aluop = ALU_XOR;
          default: dec_aluop = ALU_OR;
        endcase
      end
      OP_LUI: begin
        dec_aluop   = ALU_OR;
        dec_alusel  = SEL_LOGIC;
        dec_re1     = 1'b1;
        dec_imm2    = DATA_W'({imm, 16'h0000});
        dec_wd      = REG_AW'(rt);
        dec_invalid = 1'b0;
      end
      OP_SPECIAL: begin
        case (funct)
          FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            dec_alusel  = SEL_LOGIC;
            dec_re1     = 1'b1;
            dec_re2     = 1'b1;
            dec_wd      = REG_AW'(rd);
            dec_invalid = 1'b0;
            case (funct)
              FN_AND:  dec_aluop = ALU_AND;
              FN_OR:   dec_aluop = ALU_OR;
              FN_XOR:  dec_aluop = ALU_XOR;
              default: dec_aluop = ALU_NOR;
            endcase
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            // Shifts take the shift amount on port 1 and only read rt.
            dec_alusel  = SEL_SHIFT;
            dec_re2     = 1'b1;
            dec_imm1    = DATA_W'(shamt);
            dec_wd      = REG_AW'(rd);
            dec_invalid = 1'b0;
            case (funct)
              FN_SLL:  dec_aluop = ALU_SLL;
              FN_SRL:  dec_aluop = ALU_SRL;
              default: dec_aluop = ALU_SRA;
            endcase
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign dec_wreg = ~dec_invalid & (dec_wd != '0);

  logic [REG_AW-1:0] addr1, addr2;
  assign addr1 = REG_AW'(rs);
  assign addr2 = REG_AW'(rt);

  assign reg1_read_o = ~rst & dec_re1;
  assign reg2_read_o = ~rst & dec_re2;
  assign reg1_addr_o = rst ? '0 : addr1;
  assign reg2_addr_o = rst ? '0 : addr2;

  function automatic logic [DATA_W-1:0] resolve(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] rf_data,
    input logic              ex_wreg,
    input logic              ex_load,
    input logic [REG_AW-1:0] ex_wd,
    input logic [DATA_W-1:0] ex_wdata,
    input logic              mem_wreg,
    input logic [REG_AW-1:0] mem_wd,
    input logic [DATA_W-1:0] mem_wdata
  );
    if (addr == '0)
      return '0;
    else if (ex_wreg && !ex_load && ex_wd == addr)
      return ex_wdata;
    else if (mem_wreg && mem_wd == addr)
      return mem_wdata;
    else
      return rf_data;
  endfunction

  logic [DATA_W-1:0] opnd1, opnd2;

  always_comb begin
    opnd1 = dec_imm1;
    opnd2 = dec_imm2;
    if (dec_re1)
      opnd1 = resolve(addr1, reg1_data_i, ex_wreg_i, ex_is_load_i, ex_wd_i,
                      ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);
    if (dec_re2)
      opnd2 = resolve(addr2, reg2_data_i, ex_wreg_i, ex_is_load_i, ex_wd_i,
                      ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);
  end

  logic hazard, load, capture;

  // A load in EX cannot be forwarded; hold the consumer until it reaches MEM.
  assign hazard = bus.in_valid_i & ex_is_load_i & ex_wreg_i & (ex_wd_i != '0) &
                  ((dec_re1 & (addr1 == ex_wd_i)) | (dec_re2 & (addr2 == ex_wd_i)));
  assign load    = bus.out_ready_i | (state_q == S_EMPTY);
  assign capture = load & bus.in_valid_i & ~hazard;
  assign bus.in_ready_o = ~rst & load & ~hazard;

  always_comb begin
    state_d = state_q;
    if (load)
      state_d = capture ? S_FULL : S_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  logic [7:0]        aluop_q;
  logic [2:0]        alusel_q;
  logic [DATA_W-1:0] reg1_q, reg2_q;
  logic [REG_AW-1:0] wd_q;
  logic              wreg_q;
  logic [31:0]       pc_q;
  logic              invalid_q;
  logic [CNT_W-1:0]  stall_q;

  always_ff @(posedge clk) begin
    if (rst || (load && !capture)) begin
      aluop_q   <= '0;
      alusel_q  <= '0;
      reg1_q    <= '0;
      reg2_q    <= '0;
      wd_q      <= '0;
      wreg_q    <= 1'b0;
      pc_q      <= '0;
      invalid_q <= 1'b0;
    end else if (capture) begin
      aluop_q   <= dec_aluop;
      alusel_q  <= dec_alusel;
      reg1_q    <= opnd1;
      reg2_q    <= opnd2;
      wd_q      <= dec_wd;
      wreg_q    <= dec_wreg;
      pc_q      <= bus.pc_i;
      invalid_q <= dec_invalid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (hazard && load && stall_q != '1)
      stall_q <= stall_q + CNT_W'(1);
  end

  assign bus.out_valid_o    = (state_q == S_FULL);
  assign bus.aluop_o        = aluop_q;
  assign bus.alusel_o       = alusel_q;
  assign bus.reg1_o         = reg1_q;
  assign bus.reg2_o         = reg2_q;
  assign bus.wd_o           = wd_q;
  assign bus.wreg_o         = wreg_q;
  assign bus.pc_o           = pc_q;
  assign bus.invalid_inst_o = invalid_q;
  assign stall_cnt_o        = stall_q;

endmodule
